// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Optional macro MULDIV_EARLY_TERM_EN ends multiply iterations once the remaining multiplier is zero.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               state, state_nx;
   logic [2*WIDTH-1:0]   acc, mcand, prod_s;
   logic [WIDTH-1:0]     mplier, a_abs, b_abs, quo_s, rem_s;
   logic [WIDTH:0]       diff;
   logic [CW-1:0]        cnt;
   logic                 is_div, neg_q, neg_r, accept, div0, last, sgn;

   assign sgn    = ~op[0];
   assign a_abs  = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign b_abs  = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
   assign diff   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand[WIDTH-1:0]};
   assign prod_s = neg_q ? -acc : acc;
   assign quo_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_s  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   assign busy   = state != IDLE;
`ifdef MULDIV_EARLY_TERM_EN
   assign last   = cnt == CNT_LAST || (!is_div && mplier[WIDTH-1:1] == '0);
`else
   assign last   = cnt == CNT_LAST;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // next state; a zero divisor is answered directly from IDLE
   always_comb begin
      state_nx = state;
      div0     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            div0     = start && op[1] && rt_data == '0;
            accept   = start && !div0;
            state_nx = accept ? CALC : IDLE;
         end
         CALC:    state_nx = last ? FIX : CALC;
         default: state_nx = IDLE;
      endcase
   end

   // operand capture, shift-add / restoring-divide iterations, HI/LO update
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else begin
         done <= div0 || state == FIX;
         if (accept) begin
            is_div <= op[1];
            neg_q  <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r  <= sgn && rs_data[WIDTH-1];
            cnt    <= '0;
            acc    <= op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
            mcand  <= {{WIDTH{1'b0}}, op[1] ? b_abs : a_abs};
            mplier <= b_abs;
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (is_div)
               acc <= diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else begin
               acc    <= acc + (mplier[0] ? mcand : '0);
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
         end
         if (div0) begin
            hi <= rs_data;
            lo <= DIV0_LO;
         end else if (state == FIX)
            {hi, lo} <= is_div ? {rem_s, quo_s} : prod_s;
         else if (state == IDLE && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
endmodule
